// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one master port, grant held for the whole cyc.
// A per-strobe watchdog aborts cycles a dead slave never acks, signalling err to the owner.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no owner; arbitrate among wbm_cyc_i on the next edge
//   S_GRANT | grant_q owns the shared port; request/ack passed through
//   S_ABORT | watchdog fired; shared port quiet until owner drops cyc
`timescale 1ns/1ps
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NM-1:0]          wbm_cyc_i,
  input  logic [NM-1:0]          wbm_stb_i,
  input  logic [NM-1:0]          wbm_we_i,
  input  logic [NM*(DW/8)-1:0]   wbm_sel_i,
  input  logic [NM*AW-1:0]       wbm_adr_i,
  input  logic [NM*DW-1:0]       wbm_dat_i,
  output logic [DW-1:0]          wbm_dat_o,
  output logic [NM-1:0]          wbm_ack_o,
  output logic [NM-1:0]          wbm_err_o,
  output logic                   wbs_cyc_o,
  output logic                   wbs_stb_o,
  output logic                   wbs_we_o,
  output logic [(DW/8)-1:0]      wbs_sel_o,
  output logic [AW-1:0]          wbs_adr_o,
  output logic [DW-1:0]          wbs_dat_o,
  input  logic [DW-1:0]          wbs_dat_i,
  input  logic                   wbs_ack_i
);

  localparam int SEL = DW / 8;
  localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NM-1:0] err_q, err_d;

  logic [NM-1:0] grant_oh;
  logic          g_cyc, g_stb, in_grant;
  logic [TW-1:0] timer_inc;
  logic [GW:0]   rr_sum;
  logic [GW-1:0] rr_cand;
  logic [GW-1:0] pick;
  logic          pick_vld;

  assign grant_oh  = NM'(1) << grant_q;
  assign g_cyc     = wbm_cyc_i[grant_q];
  assign g_stb     = wbm_stb_i[grant_q];
  assign in_grant  = (state_q == S_GRANT);
  assign timer_inc = timer_q + TW'(1);

  // First requester after last_q, wrapping modulo NM; last_q itself is checked last.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NM; i++) begin
      rr_sum = {1'b0, last_q} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(NM)) rr_sum = rr_sum - (GW+1)'(NM);
      rr_cand = rr_sum[GW-1:0];
      if (!pick_vld && wbm_cyc_i[rr_cand]) begin
        pick     = rr_cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          last_d  = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!g_cyc) begin
          state_d = S_IDLE;
        end else if (WD_EN && g_stb && !wbs_ack_i) begin
          // an ack in the final waiting cycle keeps us out of this branch, so ack wins the race
          if (timer_inc == TO_V) begin
            err_d   = grant_oh;
            state_d = S_ABORT;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      S_ABORT: begin
        if (!g_cyc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NM - 1);
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign wbs_cyc_o = in_grant & g_cyc;
  assign wbs_stb_o = in_grant & g_stb;
  assign wbs_we_o  = in_grant & wbm_we_i[grant_q];
  assign wbs_sel_o = in_grant ? wbm_sel_i[grant_q*SEL +: SEL] : '0;
  assign wbs_adr_o = in_grant ? wbm_adr_i[grant_q*AW +: AW] : '0;
  assign wbs_dat_o = in_grant ? wbm_dat_i[grant_q*DW +: DW] : '0;

  assign wbm_ack_o = (in_grant && wbs_ack_i) ? grant_oh : '0;
  assign wbm_err_o = err_q;
  assign wbm_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NM=2, TIMEOUT=4): single master, contention,
// lock, watchdog abort, ack/timeout race and mid-cycle reset.
`timescale 1ns/1ps
module tb_wb_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cyc, stb, we;
  logic [7:0]  sel;
  logic [63:0] adr, dat;
  logic [31:0] m_dat;
  logic [1:0]  m_ack, m_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_ack;
  logic [31:0] mem;

  int n_checks;
  int n_errors;

  wb_rr_arbiter #(.AW(32), .DW(32), .NM(2), .TIMEOUT(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbm_cyc_i (cyc),
    .wbm_stb_i (stb),
    .wbm_we_i  (we),
    .wbm_sel_i (sel),
    .wbm_adr_i (adr),
    .wbm_dat_i (dat),
    .wbm_dat_o (m_dat),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_we_o  (s_we),
    .wbs_sel_o (s_sel),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_dat_o),
    .wbs_dat_i (s_dat_i),
    .wbs_ack_i (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input bit m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      cyc[1] = c; stb[1] = s; we[1] = w; sel[7:4] = 4'hF; adr[63:32] = a; dat[63:32] = d;
    end else begin
      cyc[0] = c; stb[0] = s; we[0] = w; sel[3:0] = 4'hF; adr[31:0] = a; dat[31:0] = d;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    s_ack = 1'b0; s_dat_i = '0; mem = '0;

    #12;
    chk("rst_cyc", s_cyc, 0);
    chk("rst_stb", s_stb, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    rst_n = 1'b1;
    step();

    // single master write then read back
    set_m(0, 1, 1, 1, 32'h2300_0000, 32'hA5A5_1234);
    #1;
    chk("lat_stb_lo", s_stb, 0);
    step();
    chk("wr_stb", s_stb, 1);
    chk("wr_adr", s_adr, 32'h2300_0000);
    chk("wr_dat", s_dat_o, 32'hA5A5_1234);
    chk("wr_we", s_we, 1);
    chk("wr_sel", s_sel, 4'hF);
    mem = s_dat_o;
    s_ack = 1'b1;
    #1;
    chk("wr_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    #1;
    chk("drop_cyc", s_cyc, 0);
    step();
    set_m(0, 1, 1, 0, 32'h2300_0000, 0);
    step();
    chk("rd_we", s_we, 0);
    s_dat_i = mem;
    s_ack = 1'b1;
    #1;
    chk("rd_ack", m_ack, 2'b01);
    chk("rd_dat", m_dat, 32'hA5A5_1234);
    step();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    step();

    // contention right after reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    set_m(0, 1, 1, 0, 32'h100, 0);
    set_m(1, 1, 1, 0, 32'h200, 0);
    step();
    chk("c1_adr", s_adr, 32'h100);
    s_ack = 1'b1;
    #1;
    chk("c1_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, 0, 0);
    #1;
    chk("c1_drop", s_cyc, 0);
    step();
    chk("c_idle_gap", s_cyc, 0);
    step();
    chk("c2_adr", s_adr, 32'h200);
    s_ack = 1'b1;
    #1;
    chk("c2_ack", m_ack, 2'b10);
    step();
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, 0, 0);
    step();
    set_m(0, 1, 1, 0, 32'h100, 0);
    set_m(1, 1, 1, 0, 32'h200, 0);
    step();
    chk("c3_adr", s_adr, 32'h100);

    // continuous requests: owner releases for one edge and re-requests
    for (int k = 0; k < 4; k++) begin
      chk("alt_adr", s_adr, (k % 2 == 1) ? 32'h200 : 32'h100);
      if (k % 2 == 1) set_m(1, 0, 0, 0, 0, 0);
      else            set_m(0, 0, 0, 0, 0, 0);
      step();
      if (k % 2 == 1) set_m(1, 1, 1, 0, 32'h200, 0);
      else            set_m(0, 1, 1, 0, 32'h100, 0);
      #1;
      chk("alt_idle", s_cyc, 0);
      step();
    end

    // lock: m1 owns the bus for three strobes while m0 waits
    set_m(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("lk_adr", s_adr, 32'h200);
    set_m(0, 1, 1, 0, 32'h100, 0);
    for (int j = 0; j < 3; j++) begin
      s_ack = 1'b1;
      #1;
      chk("lk_ack", m_ack, 2'b10);
      step();
    end
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, 0, 0);
    #1;
    chk("lk_rel_ack", m_ack, 0);
    step();
    chk("lk_idle", s_cyc, 0);
    step();
    chk("lk_m0", s_adr, 32'h100);
    set_m(0, 0, 0, 0, 0, 0);
    step();

    // watchdog: slave never acks
    set_m(1, 1, 1, 0, 32'h300, 0);
    step();
    chk("to_stb", s_stb, 1);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("to_noerr", m_err, 0);
    end
    step();
    chk("to_err", m_err, 2'b10);
    chk("to_abort_cyc", s_cyc, 0);
    s_ack = 1'b1;
    #1;
    chk("to_late_ack", m_ack, 0);
    step();
    chk("to_err_pulse", m_err, 0);
    chk("to_abort_hold", s_cyc, 0);
    chk("to_late_ack2", m_ack, 0);
    s_ack = 1'b0;
    set_m(1, 0, 0, 0, 0, 0);
    step();

    // ack lands on the cycle the watchdog would fire
    set_m(0, 1, 1, 0, 32'h400, 0);
    step();
    step();
    step();
    step();
    s_ack = 1'b1;
    #1;
    chk("race_ack", m_ack, 2'b01);
    step();
    chk("race_noerr", m_err, 0);
    chk("race_cyc", s_cyc, 1);
    s_ack = 1'b0;
    step();
    step();
    step();
    chk("race_clr", m_err, 0);
    step();
    chk("race_err_later", m_err, 2'b01);
    set_m(0, 0, 0, 0, 0, 0);
    step();

    // reset while m1 is mid-transfer
    set_m(1, 1, 1, 0, 32'h500, 0);
    step();
    chk("rm_stb", s_stb, 1);
    s_ack = 1'b1;
    #1;
    chk("rm_ack_pre", m_ack, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rm_cyc", s_cyc, 0);
    chk("rm_stb0", s_stb, 0);
    chk("rm_ack", m_ack, 0);
    chk("rm_err", m_err, 0);
    s_ack = 1'b0;
    set_m(0, 1, 1, 0, 32'h100, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("rm_m0", s_adr, 32'h100);
    chk("rm_m0_cyc", s_cyc, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
